// File: rtl/iter_div.sv
// Iterative restoring integer divider: one quotient bit per cycle, signed or unsigned,
// quotient or remainder select, with an optional fast path for divide-by-zero.
module iter_div #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_rem, quo_neg, rem_neg, div_zero;
  logic [WIDTH-1:0] dvs, quo, rem;

  logic             accept, s1_neg, s2_neg, src2_zero;
  logic [WIDTH-1:0] src1_mag, src2_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_nxt, rem_nxt, q_fin, r_fin;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready & ~flush;
  assign s1_neg    = ~op[1] & src1[WIDTH-1];
  assign s2_neg    = ~op[1] & src2[WIDTH-1];
  assign src1_mag  = s1_neg ? -src1 : src1;
  assign src2_mag  = s2_neg ? -src2 : src2;
  assign src2_zero = (src2 == '0);

  // Shift the next dividend bit into the partial remainder; a borrow means restore.
  assign trial   = {rem, quo[WIDTH-1]} - {1'b0, dvs};
  assign rem_nxt = trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

  // Divide-by-zero quotient is forced; the remainder naturally reproduces src1.
  assign q_fin = div_zero ? '1 : (quo_neg ? -quo_nxt : quo_nxt);
  assign r_fin = rem_neg ? -rem_nxt : rem_nxt;

  // NOTE: datapath registers carry no reset; nothing observable reads them until
  // a request has been accepted and loaded them, and out_valid gates the result.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvs      <= src2_mag;
      quo      <= src1_mag;
      rem      <= '0;
      op_rem   <= op[0];
      quo_neg  <= s1_neg ^ s2_neg;
      rem_neg  <= s1_neg;
      div_zero <= src2_zero;
    end else if (state == BUSY) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (EARLY_ZERO && src2_zero) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= op[0] ? src1 : '1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= op_rem ? r_fin : q_fin;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          result    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div (WIDTH=32, EARLY_ZERO=1): results, latency, stall,
// flush and reset behaviour against hand-computed values.
module tb_iter_div;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, busy;
  logic [1:0]  op;
  logic [31:0] src1, src2, result;

  int n_tests = 0;
  int n_fail  = 0;

  iter_div #(.WIDTH(32), .EARLY_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges counted including the accepting one, bounded.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    check({tag, "_inrdy_pre"}, in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_post"}, out_valid, 1'b0);
    check({tag, "_res_post"}, result, 32'h0);
    check({tag, "_inrdy_post"}, in_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    int edges;
    issue(o, a, b);
    check({tag, "_busy"}, busy, 1'b1);
    if (!out_valid) check({tag, "_res_idle0"}, result, 32'h0);
    wait_done(edges);
    check({tag, "_lat"}, edges, lat);
    check({tag, "_res"}, result, exp);
    handshake(tag);
  endtask

  initial begin
    int edges;
    logic seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; src1 = '0; src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_inrdy", in_ready, 1'b1);
    check("rst_ov", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_res", result, 32'h0);
    reset = 1'b0;

    run("s7d2_q",    2'b00, 32'd7,        32'd2,        32'h00000003, 33);
    run("s7d2_r",    2'b01, 32'd7,        32'd2,        32'h00000001, 33);
    run("sm7d2_q",   2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run("sm7d2_r",   2'b01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run("s7dm2_q",   2'b00, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run("s7dm2_r",   2'b01, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
    run("u_ff_d10",  2'b10, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 33);
    run("u100r7",    2'b11, 32'd100,      32'd7,        32'h00000002, 33);
    run("dz_q",      2'b00, 32'h12345678, 32'h0,        32'hFFFFFFFF, 1);
    run("dz_r",      2'b01, 32'h12345678, 32'h0,        32'h12345678, 1);
    run("dz_neg_r",  2'b01, 32'h80000000, 32'h0,        32'h80000000, 1);
    run("dz_neg_q",  2'b00, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFF, 1);
    run("ovf_q",     2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run("ovf_r",     2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);

    // Consumer stall in DONE.
    issue(2'b00, 32'd1000, 32'd10);
    wait_done(edges);
    check("stall_lat", edges, 33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_ov", out_valid, 1'b1);
      check("stall_res", result, 32'd100);
      check("stall_inrdy", in_ready, 1'b0);
    end
    handshake("stall");

    // Flush at iteration 15, then a clean request.
    issue(2'b00, 32'd100, 32'd7);
    repeat (15) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_inrdy", in_ready, 1'b1);
    check("flush_busy", busy, 1'b0);
    check("flush_ov", out_valid, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("flush_no_ov", seen, 1'b0);
    run("post_flush", 2'b00, 32'd100, 32'd7, 32'd14, 33);

    // Flush coinciding with a request must not accept it.
    op = 2'b00; src1 = 32'd9; src2 = 32'd3;
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_req_busy", busy, 1'b0);
    check("flush_req_inrdy", in_ready, 1'b1);

    // Reset in DONE with the consumer stalled and a request pending.
    issue(2'b00, 32'd7, 32'd2);
    wait_done(edges);
    check("rdone_ov_pre", out_valid, 1'b1);
    reset = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    check("rdone_inrdy", in_ready, 1'b1);
    check("rdone_ov", out_valid, 1'b0);
    check("rdone_busy", busy, 1'b0);
    check("rdone_res", result, 32'h0);

    // Reset mid-BUSY abandons the operation.
    issue(2'b01, 32'd50, 32'd6);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rbusy_busy", busy, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("rbusy_no_ov", seen, 1'b0);
    run("post_reset", 2'b01, 32'd50, 32'd6, 32'd2, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
